// File: rtl/blit_font_fetch_if.sv
// Bundle of request, memory and pixel-stream signals for blit_font_fetch.
// Optional out_wr_en exists only when BLIT_FONT_TRANSPARENT_EN is defined.
interface blit_font_fetch_if #(
  parameter int ADDR_W = 26
);
  // Every channel is valid/ready: a beat transfers on the rising clock edge
  // where valid and ready are both 1; the sender holds its payload stable
  // while valid is high and ready is low (the memory port uses mem_req/mem_ack).
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_src_addr;
  logic [5:0]        in_width;
  logic [7:0]        in_fg_color;
  logic [7:0]        in_bg_color;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_color;
  logic              out_last;
`ifdef BLIT_FONT_TRANSPARENT_EN
  logic              out_wr_en;
`endif

  modport master (
    input  in_valid, in_src_addr, in_width, in_fg_color, in_bg_color,
    input  mem_ack, mem_rvalid, mem_rdata, out_ready,
    output in_ready, mem_req, mem_addr, out_valid, out_color, out_last
`ifdef BLIT_FONT_TRANSPARENT_EN
    , output out_wr_en
`endif
  );

  modport slave (
    output in_valid, in_src_addr, in_width, in_fg_color, in_bg_color,
    output mem_ack, mem_rvalid, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_addr, out_valid, out_color, out_last
`ifdef BLIT_FONT_TRANSPARENT_EN
    , input out_wr_en
`endif
  );
endinterface

// File: rtl/blit_font_fetch.sv
// Fetches one 32-bit glyph row and expands it LSB-first into fg/bg pixels.
// Define BLIT_FONT_TRANSPARENT_EN to add out_wr_en (0 for background pixels).
module blit_font_fetch #(
  parameter int ADDR_W = 26
) (
  input  logic                clock,
  input  logic                reset,
  blit_font_fetch_if.master   bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_EXPAND = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  width_q;
  logic [7:0]  fg_q;
  logic [7:0]  bg_q;
  logic [31:0] shift_q;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_nxt;
  logic [5:0]  width_clamped;
  logic        wr_en_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.in_src_addr[1:0];
  assign dbg_state        = state;
  assign cnt_nxt          = cnt_q + 6'd1;
  assign width_clamped    = (bus.in_width > 6'd32) ? 6'd32 : bus.in_width;

`ifdef BLIT_FONT_TRANSPARENT_EN
  assign bus.out_wr_en = wr_en_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      width_q       <= 6'd0;
      fg_q          <= 8'd0;
      bg_q          <= 8'd0;
      shift_q       <= 32'd0;
      cnt_q         <= 6'd0;
      wr_en_q       <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_color <= 8'd0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            width_q <= width_clamped;
            fg_q    <= bus.in_fg_color;
            bg_q    <= bus.in_bg_color;
            // A zero-width row is consumed here with no memory traffic.
            if (width_clamped != 6'd0) begin
              state        <= S_REQ;
              bus.in_ready <= 1'b0;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.in_src_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (state == S_REQ && bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= S_WAIT;
          end
          // Data may arrive with the ack itself, or any time after it.
          if ((state == S_WAIT || bus.mem_ack) && bus.mem_rvalid) begin
            state         <= S_EXPAND;
            shift_q       <= bus.mem_rdata;
            cnt_q         <= 6'd0;
            bus.out_valid <= 1'b1;
            bus.out_color <= bus.mem_rdata[0] ? fg_q : bg_q;
            bus.out_last  <= (width_q == 6'd1);
            wr_en_q       <= bus.mem_rdata[0];
          end
        end
        S_EXPAND: begin
          if (bus.out_ready) begin
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_nxt;
            if (bus.out_last) begin
              state         <= S_IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
            end else begin
              // Present the next pixel, which is bit 1 before the shift lands.
              bus.out_color <= shift_q[1] ? fg_q : bg_q;
              bus.out_last  <= (cnt_nxt == width_q - 6'd1);
              wr_en_q       <= shift_q[1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/blit_font_fetch.md
BLIT_FONT_FETCH -- requirements
Module: blit_font_fetch

Interface
REQ-001 Parameter: ADDR_W, 26, byte address width of the source/font memory port.
REQ-002 clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-004 in_valid  input  1  row-fetch request present.
REQ-005 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 in_src_addr  input  ADDR_W  byte address of a glyph row; bits [1:0] ignored.
REQ-007 in_width  input  6  pixels to emit from the row, 0..63.
REQ-008 in_fg_color, in_bg_color  input  8 each  colours for set and clear bits.
REQ-009 mem_req  output  1  read request to memory.
REQ-010 mem_addr  output  ADDR_W  word-aligned read address, bits [1:0] = 0.
REQ-011 mem_ack  input  1  memory accepted the request this cycle.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rdata  input  32  read data word.
REQ-014 out_valid  output  1  pixel present.
REQ-015 out_ready  input  1  downstream accepts pixel.
REQ-016 out_color  output  8  pixel colour.
REQ-017 out_last  output  1  final pixel of the current row.

Function
REQ-018 The block SHALL implement states IDLE, REQ, WAIT and EXPAND.
REQ-019 IDLE: on in_valid && in_ready, the block SHALL latch address, width (clamped to 32 if >32) and both colours; width 0 -> remain IDLE, issue no memory access, emit no pixels; otherwise -> REQ.
REQ-020 REQ: mem_req SHALL be 1 with mem_addr = {latched addr[ADDR_W-1:2], 2'b00}, held stable until mem_ack; on mem_ack -> WAIT.
REQ-021 If mem_ack and mem_rvalid are both high in the same REQ cycle, the block SHALL capture mem_rdata and go directly to EXPAND.
REQ-022 WAIT: the block SHALL ignore mem_rdata until mem_rvalid; on mem_rvalid it SHALL capture mem_rdata into a 32-bit shift register, zero the pixel counter and go to EXPAND.
REQ-023 EXPAND: out_valid SHALL be 1; out_color = fg if shift bit 0 is 1, else bg (LSB = leftmost pixel).
REQ-024 On out_valid && out_ready, the block SHALL shift right by 1 and increment the counter; out_last SHALL be 1 when counter == width-1.
REQ-025 The transfer with out_last SHALL return the block to IDLE; in_ready SHALL rise the following cycle (no back-to-back overlap).
REQ-026 With out_ready low, out_color, out_last and the state SHALL be held unchanged.
REQ-027 Latency: the first pixel SHALL appear the cycle after rdata capture; a full row SHALL take exactly width cycles in EXPAND when out_ready is held high.
REQ-028 mem_rvalid outside WAIT/REQ SHALL be ignored.

Reset
REQ-029 While reset is 0 at a clock edge: state = IDLE, in_ready = 1 after release, mem_req = 0, out_valid = 0, out_last = 0, out_color = 0, counter = 0, shift register = 0.
REQ-030 Reset in any state, including mid-WAIT or mid-EXPAND, SHALL abandon the row without emitting further pixels; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-031 Macro BLIT_FONT_TRANSPARENT_EN: when defined, the block SHALL add output out_wr_en (1 bit) = shift bit 0, so bg pixels are presented with out_wr_en = 0 (transparent) while still consuming a cycle; when undefined, out_wr_en SHALL not exist and every pixel is an opaque write.

Verification
REQ-032 Reset, then in_src_addr=0x000103, width=8, fg=0xFF, bg=0x11, rdata=0x000000A5 -> mem_addr=0x000100; pixels FF,11,FF,11,11,FF,11,FF; out_last on the 8th.
REQ-033 width=0 -> in_ready stays 1, mem_req never asserts, out_valid stays 0.
REQ-034 width=40, rdata=0xFFFFFFFF -> exactly 32 fg pixels, out_last on the 32nd.
REQ-035 mem_ack held low 5 cycles, then mem_ack and mem_rvalid together -> mem_addr stable throughout; EXPAND entered the next cycle.
REQ-036 out_ready toggled 1,0,0,1 during EXPAND -> out_color/out_last held during the low cycles; no pixel skipped or duplicated.
REQ-037 reset asserted in WAIT, then mem_rvalid pulses after release -> no out_valid; the next request completes normally. With BLIT_FONT_TRANSPARENT_EN, rdata=0x1 and width=2 -> out_wr_en sequence 1,0.
